// File: rtl/nibble_rx_pkg.sv
// Shared types and line-level constants for the nibble_rx serial front end.
package nibble_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } state_e;

   localparam logic RX_IDLE_LEVEL  = 1'b1;
   localparam logic RX_START_LEVEL = 1'b0;

endpackage

// File: rtl/nibble_rx_shreg.sv
// WIDTH-bit right-shift register; serial bits enter at the MSB so an LSB-first
// frame lands in natural bit order.
module nibble_rx_shreg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             shift_en_i,
   input  logic             din_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (shift_en_i) sr_d = {din_i, sr_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign q_o = sr_q;

endmodule

// File: rtl/nibble_rx.sv
// Framed serial receiver: start, WIDTH data bits LSB first, optional even
// parity (NIBBLE_RX_PARITY_EN), stop. Pulses valid or frame_err per frame.
module nibble_rx
   import nibble_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             tick,
   input  logic             rxd,
   output logic [WIDTH-1:0] d_out,
   output logic             valid,
   output logic             frame_err,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             shift_en;
   logic [WIDTH-1:0] sr;
   logic             perr;
   logic             last_bit;

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef NIBBLE_RX_PARITY_EN
   logic perr_q, perr_d;
   assign perr = perr_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) perr_q <= 1'b0;
      else     perr_q <= perr_d;
   end

   always_comb begin
      perr_d = perr_q;
      if (tick && state_q == PAR)  perr_d = (^sr) ^ rxd;
      if (tick && state_q == STOP) perr_d = 1'b0;
   end
`else
   assign perr = 1'b0;
`endif

   nibble_rx_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk        (clk),
      .clr        (clr),
      .shift_en_i (shift_en),
      .din_i      (rxd),
      .q_o        (sr)
   );

   // State and output registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         d_out_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_out_q <= d_out_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            IDLE: if (rxd == RX_START_LEVEL) state_d = DATA;
            DATA: if (last_bit) begin
`ifdef NIBBLE_RX_PARITY_EN
               state_d = PAR;
`else
               state_d = STOP;
`endif
            end
            PAR:  state_d = STOP;
            STOP: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath and pulse outputs; pulses self-clear whenever tick is low
   always_comb begin
      cnt_d    = cnt_q;
      d_out_d  = d_out_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      shift_en = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: if (rxd == RX_START_LEVEL) cnt_d = '0;
            DATA: begin
               shift_en = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
            end
            STOP: begin
               if (rxd == RX_IDLE_LEVEL && !perr) begin
                  d_out_d = sr;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign d_out     = d_out_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_rx.sv
// Scoreboard bench for nibble_rx; parity cases run when NIBBLE_RX_PARITY_EN is defined.
module tb_nibble_rx;

   typedef struct packed {
      logic       is_err;
      logic [3:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       tick = 1'b0;
   logic       rxd = 1'b1;
   logic [3:0] d_out;
   logic       valid;
   logic       frame_err;
   logic       busy;

   exp_t       exp_q[$];
   logic [3:0] last_d;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   nibble_rx #(.WIDTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .clr       (clr),
      .tick      (tick),
      .rxd       (rxd),
      .d_out     (d_out),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: every output pulse must match the head of the expectation queue
   always @(negedge clk) begin
      if (!clr && (valid || frame_err)) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b d_out=%0h with nothing expected at %0t",
                     valid, frame_err, d_out, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_valid", 32'(valid), 32'(!e.is_err));
            check("pulse_frame_err", 32'(frame_err), 32'(e.is_err));
            check("pulse_d_out", 32'(d_out), 32'(e.data));
         end
      end
   end

   task automatic send_bit(input logic b, input int gap);
      rxd  = b;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      rxd  = 1'b1;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame(input logic [3:0] data, input logic stop_b,
                             input logic par_ok, input int gap);
      logic [3:0] d;
      logic       good;
      exp_t       e;
      d = data;
      good = stop_b && par_ok;
      send_bit(1'b0, gap);
      check("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) send_bit(d[i], gap);
`ifdef NIBBLE_RX_PARITY_EN
      send_bit(par_ok ? (^d) : ~(^d), 0);
      repeat (gap) begin @(posedge clk); #1; end
`endif
      if (good) last_d = data;
      e.is_err = !good;
      e.data   = last_d;
      exp_q.push_back(e);
      send_bit(stop_b, gap);
      check("busy_after_stop", 32'(busy), 32'd0);
   endtask

   initial begin
      last_d = 4'h0;
      #2 clr = 1'b1;
      #1;
      check("reset_d_out", 32'(d_out), 32'h0);
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      #1 clr = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Idle ticks with line high must not start a frame
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      check("idle_busy", 32'(busy), 32'd0);

      send_frame(4'hA, 1'b1, 1'b1, 0);
      send_frame(4'hF, 1'b0, 1'b1, 0);
      send_frame(4'h5, 1'b1, 1'b1, 2);

      // Back-to-back frames with no idle gap
      send_frame(4'hC, 1'b1, 1'b1, 0);
      send_frame(4'h6, 1'b1, 1'b1, 0);

      // Mid-frame reset discards the partial frame
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      clr = 1'b1;
      #1;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_d_out", 32'(d_out), 32'h0);
      check("midreset_valid", 32'(valid), 32'd0);
      last_d = 4'h0;
      #1 clr = 1'b0;
      @(posedge clk); #1;
      send_frame(4'h3, 1'b1, 1'b1, 0);

`ifdef NIBBLE_RX_PARITY_EN
      send_frame(4'h7, 1'b1, 1'b1, 0);
      send_frame(4'h7, 1'b1, 1'b0, 0);
      send_frame(4'h9, 1'b1, 1'b0, 1);
`endif

      repeat (5) begin @(posedge clk); #1; end
      check("final_d_out", 32'(d_out), 32'(last_d));
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/nibble_rx.md
Name: nibble_rx

Overview:
- Serial-to-parallel front end for the 4-bit output register stage.
- Receives framed serial data on one wire, one bit per `tick` strobe.
- Presents the assembled word on `d_out` with a one-clock `valid` pulse. Downstream logic uses that pulse to load the word into the register stage.
- Sits directly upstream of that register and drives its data input.

Parameters:
- WIDTH, 4, data bits per frame (≥2); also the width of `d_out`.
- CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- tick  input  1  bit-rate enable. Serial input is sampled only in clk cycles where tick=1.
- rxd  input  1  serial line; idles high; frame sent LSB first.
- d_out  output  WIDTH  last correctly received word; holds between frames.
- valid  output  1  one-clk pulse; d_out was updated this cycle.
- frame_err  output  1  one-clk pulse; stop bit (or parity, if enabled) was bad.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Frame format: start(0), WIDTH data bits LSB first, [parity], stop(1).
- Reset (clr=1, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - d_out=0, valid=0, frame_err=0, busy=0.
  - Applies immediately; a frame in progress is discarded with no pulse.
- All transitions below occur only on clk edges where tick=1. With tick=0 the state and all registers hold, except that valid and frame_err return to 0.
- IDLE:
  - rxd=0 → DATA, counter=0 (the start bit is consumed here).
  - rxd=1 → stay in IDLE.
- DATA:
  - Each tick: sr <= {rxd, sr[WIDTH-1:1]}, counter++.
  - On the tick where counter==WIDTH-1 (the last data bit is taken) → PAR if PARITY_EN is defined, else STOP.
- PAR: on tick, store perr = (^sr) ^ rxd (even parity; perr=1 means bad) → STOP.
- STOP, on tick:
  - rxd=1 and perr=0: d_out<=sr; valid=1 for exactly one clk.
  - Otherwise: frame_err=1 for one clk; d_out unchanged.
  - Either way → IDLE; perr cleared.
- Latency: valid/d_out update on the same clk edge as the stop-bit tick (registered outputs).
- Back-to-back frames: a start bit on the tick immediately after the stop tick is accepted. No gap is required.
- tick held high continuously: one bit per clk; legal.
- A glitch low on rxd in IDLE is treated as a start bit (no mid-bit recheck). A malformed frame is caught by the stop check.
- busy is combinational from state: high in DATA, PAR and STOP.

Optional Feature:
- Macro: NIBBLE_RX_PARITY_EN.
- Defined: a PAR state follows DATA.
  - Frame length is WIDTH+3 ticks.
  - A parity mismatch produces frame_err and suppresses valid and the d_out update.
- Undefined: no PAR state and perr is tied to 0. Frame length is WIDTH+2 ticks.

Decomposition:
- Shared package nibble_pkg holds:
  - state enum (IDLE, DATA, PAR, STOP), 2-bit encoding;
  - constants RX_IDLE_LEVEL=1'b1, RX_START_LEVEL=1'b0.
- One natural sub-module: nibble_rx_shreg, the WIDTH-bit right-shift register with shift-enable and clear.
- FSM, counter and output registers stay in the top.

Test Plan:
- Reset: clr pulse while rxd=1 → d_out=4'h0, valid=0, frame_err=0, busy=0 immediately, before any clk edge.
- Good frame 4'hA (parity off), tick=1 every clk:
  - rxd sequence 0,0,1,0,1,1 → d_out=4'hA with valid=1 on the 6th tick edge only.
  - busy high for ticks 2–6.
- Bad stop bit: rxd 0,1,1,1,1,0 → frame_err=1 for one clk; valid=0; d_out keeps its previous value (4'hA).
- tick every 3rd clk, frame for 4'h5 (bits 0,1,0,1,0,1) → same result as tick every clk; valid still exactly one clk wide.
- Mid-frame reset: assert clr after 2 data bits, then send a full 4'h3 frame → d_out=4'h3; no spurious valid/frame_err.
- NIBBLE_RX_PARITY_EN defined, 4'h7 frame:
  - Parity bit 1 → valid, d_out=4'h7.
  - Parity bit 0 → frame_err, d_out unchanged.
